// File: rtl/data_ram_sync_if.sv
// Request/response bus for data_ram_sync: valid/ready requests in,
// registered read responses and status flags out.
interface data_ram_sync_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              wr_err;
    logic              init_done;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, wr_err, init_done
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, wr_err, init_done
    );
endinterface

// File: rtl/data_ram_sync.sv
// Single-port synchronous data RAM with a post-reset clear sweep and range checks.
// Optional per-word even parity with a parity_err output when DATA_RAM_PARITY_EN is defined.
module data_ram_sync #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 65536
) (
    input  logic           clk,
    input  logic           rst_n,
    data_ram_sync_if.slave bus
`ifdef DATA_RAM_PARITY_EN
    ,
    output logic           parity_err
`endif
);

    localparam int CLR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DATA_RAM_PARITY_EN
    localparam int STORE_W = DATA_W + 1;
`else
    localparam int STORE_W = DATA_W;
`endif
    localparam logic [ADDR_W:0]  DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
    localparam logic [CLR_W-1:0] LAST_ADDR = CLR_W'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        IDLE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [STORE_W-1:0] mem [0:DEPTH-1];

    logic [CLR_W-1:0]   clr_addr;
    logic               clr_last;
    logic               ready_q;
    logic               init_done_q;
    logic               rsp_valid_q;
    logic [DATA_W-1:0]  rsp_rdata_q;
    logic               rsp_err_q;
    logic               wr_err_q;
    logic               accept;
    logic               do_write;
    logic               do_read;
    logic               addr_ok;
    logic [CLR_W-1:0]   idx;
    logic [STORE_W-1:0] wr_word;
    logic [STORE_W-1:0] rd_word;

    // Full-width compare so addresses above DEPTH never alias onto real words.
    assign addr_ok  = ({1'b0, bus.req_addr} < DEPTH_EXT);
    assign idx      = bus.req_addr[CLR_W-1:0];
    assign clr_last = (clr_addr == LAST_ADDR);
    assign rd_word  = mem[idx];

`ifdef DATA_RAM_PARITY_EN
    assign wr_word = {^bus.req_wdata, bus.req_wdata};
`else
    assign wr_word = bus.req_wdata;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        do_write = 1'b0;
        do_read  = 1'b0;
        case (state_q)
            CLEAR: begin
                if (clr_last) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                accept   = bus.req_valid & ready_q;
                do_write = accept & bus.req_write;
                do_read  = accept & ~bus.req_write;
            end
            default: state_d = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr <= '0;
        end else if (state_q == CLEAR) begin
            clr_addr <= clr_last ? '0 : clr_addr + 1'b1;
        end
    end

    // Storage has no reset; the sweep is the only thing that zeroes it.
    always_ff @(posedge clk) begin
        if (state_q == CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (do_write && addr_ok) begin
            mem[idx] <= wr_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q     <= 1'b0;
            init_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            wr_err_q    <= 1'b0;
        end else begin
            ready_q     <= (state_d == IDLE);
            init_done_q <= (state_d == IDLE);
            rsp_valid_q <= do_read;
            rsp_err_q   <= do_read & ~addr_ok;
            wr_err_q    <= do_write & ~addr_ok;
            if (do_read) begin
                rsp_rdata_q <= addr_ok ? rd_word[DATA_W-1:0] : '0;
            end
        end
    end

`ifdef DATA_RAM_PARITY_EN
    // A correctly stored word (data plus even-parity bit) XORs to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else begin
            parity_err <= do_read & addr_ok & (^rd_word);
        end
    end
`endif

    assign bus.req_ready = ready_q;
    assign bus.init_done = init_done_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.wr_err    = wr_err_q;

endmodule

// File: doc/data_ram_sync.md
Name: data_ram_sync

Overview:
Parametrised single-port synchronous data RAM with a valid/ready request interface and a registered response channel. After reset it runs a hardware clear sweep that zeroes every word before it accepts requests. It sits between the FSM/register-file datapath and data memory, and replaces the fixed 8-bit x 64K RAM. Width, depth and address range are generic, and it adds out-of-range detection.

Parameters:
DATA_W, 8, word width in bits
ADDR_W, 16, request address width in bits
DEPTH, 65536, number of words implemented; must satisfy 1 <= DEPTH <= 2**ADDR_W; the array is declared with exactly DEPTH entries (0..DEPTH-1)

Ports:
clk  in  1  system clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_write  in  1  1 = write, 0 = read; sampled with req_valid
req_addr  in  ADDR_W  word address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  read response valid; one-cycle pulse
rsp_rdata  out  DATA_W  read data
rsp_err  out  1  read address was out of range; qualified by rsp_valid
wr_err  out  1  one-cycle pulse: the accepted write was out of range and was dropped
init_done  out  1  clear sweep has finished

Behaviour:
- Reset (rst_n=0, asynchronous), applied immediately:
  - state=CLEAR, clr_addr=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wr_err=0, init_done=0.
  - Array contents are not reset directly; only the sweep clears them.
- States: CLEAR, IDLE.
- CLEAR:
  - Each cycle: mem[clr_addr] <= 0 and clr_addr increments.
  - When clr_addr==DEPTH-1 the last zero is written and state goes to IDLE on the same edge.
  - Exactly DEPTH cycles from reset release to the first IDLE cycle.
  - req_ready=0 throughout; req_valid is ignored and never accepted.
  - clr_addr width is clog2(DEPTH), minimum 1.
- IDLE:
  - req_ready=1 and init_done=1 (both registered, both high from the first IDLE cycle).
  - Accept = req_valid & req_ready.
- Write accept with req_addr < DEPTH: mem[req_addr] <= req_wdata at that edge. No response pulse.
- Write accept with req_addr >= DEPTH: write dropped, memory unchanged, wr_err=1 for the next cycle.
- Read accept:
  - Latency 1. The next cycle has rsp_valid=1 and rsp_rdata=mem[req_addr].
  - If req_addr >= DEPTH: rsp_rdata=0 and rsp_err=1.
  - rsp_valid and rsp_err go low the cycle after unless another read was accepted.
  - rsp_rdata holds its last value when rsp_valid=0.
- Throughput: one request per cycle, any read/write mix. The response channel has no backpressure; the consumer must always sink rsp_valid.
- Write then read of the same address on consecutive cycles returns the newly written data.
- Single port: one request per cycle, so there is no simultaneous read/write hazard inside the block.
- Reset mid-sweep: the sweep restarts from 0 after release.
- Reset during IDLE: init_done drops immediately and the full sweep reruns; a read response pending at reset is lost.
- Address compare uses the full ADDR_W bits. When DEPTH==2**ADDR_W, no address is ever out of range.

Optional Feature:
Macro DATA_RAM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed as the XOR of the write data.
  - The clear sweep writes parity 0.
  - Each read recomputes parity; on mismatch, output parity_err (1 bit, added port) pulses high together with rsp_valid.
  - parity_err reset value is 0. It is never asserted for out-of-range reads.
- Not defined: no extra storage bit and no parity_err port; behaviour is otherwise identical.

Test Plan:
- Reset release with DEPTH=16, req_valid held high -> req_ready=0 for 16 cycles, then req_ready=1 and init_done=1; read of addr 5 returns rsp_rdata=0x00 one cycle later.
- Write addr 0x0003=0xA5, then read 0x0003 on the very next cycle -> rsp_valid=1 and rsp_rdata=0xA5 one cycle after the read accept.
- Back-to-back reads of 0,1,2 (preloaded 0x11,0x22,0x33) -> rsp_valid high for 3 consecutive cycles with data 0x11,0x22,0x33.
- DEPTH=16, ADDR_W=16: write 0x0020=0xFF -> wr_err pulses and memory is unchanged; read 0x0020 -> rsp_valid=1, rsp_err=1, rsp_rdata=0x00.
- Write 0x5A to addr 2, assert rst_n=0 mid-run for 1 cycle -> init_done drops immediately, full DEPTH-cycle sweep reruns, read addr 2 returns 0x00.
- With DATA_RAM_PARITY_EN: write 0x07, force the stored parity bit to flip, read -> parity_err=1 together with rsp_valid.
